// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics constants for the sprite/layer pipeline
package graphics_pkg;

   localparam int COLOR_W_DEF  = 3;
   localparam int MAX_LAYERS   = 8;
   localparam int PLAYER_LAYER = 0;

   // Colours are {b,g,r}
   localparam logic [COLOR_W_DEF-1:0] COLOR_BLACK     = 3'b000;
   localparam logic [COLOR_W_DEF-1:0] COLOR_ROAD_GREY = 3'b111;
   localparam logic [COLOR_W_DEF-1:0] COLOR_PLAYER    = 3'b001;

endpackage

// File: rtl/layer_priority_mux.sv
// rtl/layer_priority_mux.sv - combinational fixed-priority layer select, lowest index wins
module layer_priority_mux
   import graphics_pkg::*;
#(
   parameter int N_LAYERS = 4,
   parameter int COLOR_W  = COLOR_W_DEF
) (
   input  logic [N_LAYERS-1:0]         on_objs,
   input  logic [N_LAYERS*COLOR_W-1:0] rgb_objs,
   input  logic [COLOR_W-1:0]          rgb_bg,
   output logic [COLOR_W-1:0]          rgb_sel
);

   // Walk from the lowest priority upward so each hit overrides the ones below it
   always_comb begin
      rgb_sel = rgb_bg;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (on_objs[i]) begin
            rgb_sel = rgb_objs[i*COLOR_W +: COLOR_W];
         end
      end
   end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority compositor with per-frame player collision snapshot
// Collision logic is built only when LAYER_COMPOSITOR_COLLISION_EN is defined.
module layer_compositor
   import graphics_pkg::*;
#(
   parameter int N_LAYERS = 4,
   parameter int COLOR_W  = COLOR_W_DEF,
   parameter int CNT_W    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        video_on,
   input  logic                        frame_start,
   input  logic [N_LAYERS-1:0]         on_objs,
   input  logic [N_LAYERS*COLOR_W-1:0] rgb_objs,
   input  logic [COLOR_W-1:0]          rgb_bg,
   output logic [COLOR_W-1:0]          rgb,
   output logic [N_LAYERS-2:0]         coll_flags,
   output logic                        coll_irq,
   output logic [CNT_W-1:0]            coll_frames
);

   logic [COLOR_W-1:0] rgb_sel;
   logic [COLOR_W-1:0] rgb_d, rgb_q;

   layer_priority_mux #(
      .N_LAYERS (N_LAYERS),
      .COLOR_W  (COLOR_W)
   ) u_mux (
      .on_objs  (on_objs),
      .rgb_objs (rgb_objs),
      .rgb_bg   (rgb_bg),
      .rgb_sel  (rgb_sel)
   );

   always_comb begin
      rgb_d = video_on ? rgb_sel : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) rgb_q <= '0;
      else        rgb_q <= rgb_d;
   end

   assign rgb = rgb_q;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
   logic [N_LAYERS-2:0] hit, snap;
   logic [N_LAYERS-2:0] accum_d, accum_q;
   logic [N_LAYERS-2:0] flags_d, flags_q;
   logic                irq_d, irq_q;
   logic [CNT_W-1:0]    frames_d, frames_q;

   always_comb begin
      hit = '0;
      for (int k = 1; k < N_LAYERS; k++) begin
         hit[k-1] = on_objs[PLAYER_LAYER] & on_objs[k] & video_on;
      end
   end

   // A hit coinciding with frame_start closes into the outgoing snapshot
   always_comb begin
      snap     = accum_q | hit;
      accum_d  = snap;
      flags_d  = flags_q;
      irq_d    = 1'b0;
      frames_d = frames_q;
      if (frame_start) begin
         accum_d = '0;
         flags_d = snap;
         irq_d   = |snap;
         if (|snap) begin
            if (frames_q != {CNT_W{1'b1}}) frames_d = frames_q + CNT_W'(1);
         end else begin
            frames_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         accum_q  <= '0;
         flags_q  <= '0;
         irq_q    <= 1'b0;
         frames_q <= '0;
      end else begin
         accum_q  <= accum_d;
         flags_q  <= flags_d;
         irq_q    <= irq_d;
         frames_q <= frames_d;
      end
   end

   assign coll_flags  = flags_q;
   assign coll_irq    = irq_q;
   assign coll_frames = frames_q;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;

   assign coll_flags  = '0;
   assign coll_irq    = 1'b0;
   assign coll_frames = '0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor (N=4, COLOR_W=3, CNT_W=2)
module tb_layer_compositor;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        video_on = 1'b0;
   logic        frame_start = 1'b0;
   logic [3:0]  on_objs = '0;
   logic [11:0] rgb_objs = 12'b100_011_010_001;
   logic [2:0]  rgb_bg = 3'b111;
   logic [2:0]  rgb;
   logic [2:0]  coll_flags;
   logic        coll_irq;
   logic [1:0]  coll_frames;

   layer_compositor #(
      .N_LAYERS (4),
      .COLOR_W  (3),
      .CNT_W    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .video_on    (video_on),
      .frame_start (frame_start),
      .on_objs     (on_objs),
      .rgb_objs    (rgb_objs),
      .rgb_bg      (rgb_bg),
      .rgb         (rgb),
      .coll_flags  (coll_flags),
      .coll_irq    (coll_irq),
      .coll_frames (coll_frames)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [2:0] rgb;
      logic [2:0] flags;
      logic       irq;
      logic [1:0] frames;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   step_no = 0;

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s step %0d: got %0h required %0h", name, idx, act, req);
   endtask

   // Monitor: every posedge presents one registered output set
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rgb", e.idx, 8'(rgb), 8'(e.rgb));
         check("coll_flags", e.idx, 8'(coll_flags), 8'(e.flags));
         check("coll_irq", e.idx, 8'(coll_irq), 8'(e.irq));
         check("coll_frames", e.idx, 8'(coll_frames), 8'(e.frames));
      end
   end

   task automatic step(input logic rst, input logic vo, input logic fs, input logic [3:0] on,
                       input logic [2:0] e_rgb, input logic [2:0] e_flags, input logic e_irq,
                       input logic [1:0] e_frames);
      exp_t e;
      @(negedge clk);
      reset       = rst;
      video_on    = vo;
      frame_start = fs;
      on_objs     = on;
      e.idx    = step_no;
      e.rgb    = e_rgb;
      e.flags  = COLL_EN ? e_flags : 3'b000;
      e.irq    = COLL_EN ? e_irq : 1'b0;
      e.frames = COLL_EN ? e_frames : 2'd0;
      exp_q.push_back(e);
      step_no++;
   endtask

   logic [1:0] frames_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      // Reset held 3 clk with all inputs active
      repeat (3) step(0, 1, 1, 4'b1111, 3'b000, 3'b000, 0, 2'd0);
      // Priority and background
      step(1, 1, 0, 4'b1010, 3'b010, 3'b000, 0, 2'd0);
      step(1, 1, 0, 4'b0000, 3'b111, 3'b000, 0, 2'd0);
      // Blanking: forced black and nothing accumulated
      step(1, 0, 0, 4'b1111, 3'b000, 3'b000, 0, 2'd0);
      step(1, 0, 1, 4'b0000, 3'b000, 3'b000, 0, 2'd0);
      // Collision snapshot from two separate overlaps
      step(1, 1, 0, 4'b0101, 3'b001, 3'b000, 0, 2'd0);
      step(1, 1, 0, 4'b1001, 3'b001, 3'b000, 0, 2'd0);
      step(1, 1, 0, 4'b0000, 3'b111, 3'b000, 0, 2'd0);
      step(1, 0, 1, 4'b0000, 3'b000, 3'b110, 1, 2'd1);
      step(1, 0, 0, 4'b0000, 3'b000, 3'b110, 0, 2'd1);
      // Clean frame to clear the counter
      step(1, 0, 1, 4'b0000, 3'b000, 3'b000, 0, 2'd0);
      // Five colliding frames, counter saturates at 3
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 0, 4'b0011, 3'b001, (k == 0) ? 3'b000 : 3'b001, 0,
              (k == 0) ? 2'd0 : frames_seq[(k == 0) ? 0 : k - 1]);
         step(1, 0, 1, 4'b0000, 3'b000, 3'b001, 1, frames_seq[k]);
      end
      // Clean frame: counter clears, no irq
      step(1, 1, 0, 4'b0001, 3'b001, 3'b001, 0, 2'd3);
      step(1, 0, 1, 4'b0000, 3'b000, 3'b000, 0, 2'd0);
      step(1, 0, 0, 4'b0000, 3'b000, 3'b000, 0, 2'd0);
      // Hit in the frame_start cycle, then back-to-back frame_start with no hits
      step(1, 1, 1, 4'b0101, 3'b001, 3'b010, 1, 2'd1);
      step(1, 1, 1, 4'b0000, 3'b111, 3'b000, 0, 2'd0);
      // Back-to-back frame_start with a hit in the cycle between
      step(1, 0, 1, 4'b0000, 3'b000, 3'b000, 0, 2'd0);
      step(1, 1, 0, 4'b1001, 3'b001, 3'b000, 0, 2'd0);
      step(1, 0, 1, 4'b0000, 3'b000, 3'b100, 1, 2'd1);
      // Reset overrides frame_start and a concurrent hit
      step(0, 1, 1, 4'b0011, 3'b000, 3'b000, 0, 2'd0);
      step(1, 0, 1, 4'b0000, 3'b000, 3'b000, 0, 2'd0);
      step(1, 0, 0, 4'b0000, 3'b000, 3'b000, 0, 2'd0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #5;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
